// File: rtl/alu_share_arbiter_pkg.sv
// Shared types for the ALU-sharing arbiter: opcode encodings, FSM states, defaults.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [3:0] {
        ALU_ADD     = 4'd0,
        ALU_SUB     = 4'd1,
        ALU_AND     = 4'd2,
        ALU_OR      = 4'd3,
        ALU_XOR     = 4'd4,
        ALU_SLL     = 4'd5,
        ALU_SRL     = 4'd6,
        ALU_SRA     = 4'd7,
        ALU_SLT     = 4'd8,
        ALU_SLTU    = 4'd9,
        ALU_NOP     = 4'd10,
        ALU_INVALID = 4'd15
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Result pattern reported for ALU_INVALID and any unassigned opcode.
    localparam logic [31:0] ALU_ERR_RESULT = 32'hDEADBEEF;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational 32-bit (XLEN) ALU shared by all requesters; flags illegal opcodes.
module alu_share_arbiter_alu
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            err
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;
    assign shamt = b[SHW-1:0];

    always_comb begin
        result = '0;
        err    = 1'b0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_NOP:  result = '0;
            default: begin
                result = XLEN'(ALU_ERR_RESULT);
                err    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one ALU among N_REQ requesters, one op in flight.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] rr_ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] winner
);

    logic found;
    int   idx;

    // Search starts just after the last winner, wrapping around.
    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(rr_ptr) + k) % N;
            if (!found && valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = PW'(idx);
            end
        end
    end

endmodule

module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int XLEN  = XLEN_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*4-1:0]    req_op,
    input  logic [N_REQ*XLEN-1:0] req_a,
    input  logic [N_REQ*XLEN-1:0] req_b,
    output logic [N_REQ-1:0]      rsp_valid,
    input  logic [N_REQ-1:0]      rsp_ready,
    output logic [XLEN-1:0]       rsp_result,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e      state_reg, state_next;
    logic [IDW-1:0]  rr_ptr_reg, winner_reg, arb_winner;
    logic [N_REQ-1:0] arb_grant;
    logic            accept, rsp_done;

    logic [3:0]      op_reg;
    logic [XLEN-1:0] a_reg, b_reg;
    logic [XLEN-1:0] alu_result, rsp_result_reg;
    logic            alu_err, rsp_err_reg;

    logic [3:0]      op_arr [N_REQ];
    logic [XLEN-1:0] a_arr  [N_REQ];
    logic [XLEN-1:0] b_arr  [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign op_arr[gi] = req_op[gi*4 +: 4];
            assign a_arr[gi]  = req_a[gi*XLEN +: XLEN];
            assign b_arr[gi]  = req_b[gi*XLEN +: XLEN];
        end
    endgenerate

    rr_arbiter #(
        .N  (N_REQ),
        .PW (IDW)
    ) u_rr_arbiter (
        .valid  (req_valid),
        .rr_ptr (rr_ptr_reg),
        .grant  (arb_grant),
        .winner (arb_winner)
    );

    alu_share_arbiter_alu #(
        .XLEN (XLEN)
    ) u_alu (
        .op     (op_reg),
        .a      (a_reg),
        .b      (b_reg),
        .result (alu_result),
        .err    (alu_err)
    );

    assign accept   = |req_ready;
    assign rsp_done = (state_reg == RESP) && rsp_ready[winner_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Grants are suppressed while reset is asserted so req_ready reads 0 during reset.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        busy      = (state_reg != IDLE);
        if (state_reg == IDLE && rst_n) begin
            req_ready = arb_grant;
        end
        if (state_reg == RESP) begin
            rsp_valid[winner_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg <= IDW'(N_REQ - 1);
            winner_reg <= '0;
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
        end else if (accept) begin
            rr_ptr_reg <= arb_winner;
            winner_reg <= arb_winner;
            op_reg     <= op_arr[arb_winner];
            a_reg      <= a_arr[arb_winner];
            b_reg      <= b_arr[arb_winner];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result_reg <= '0;
            rsp_err_reg    <= 1'b0;
        end else if (state_reg == EXEC) begin
            rsp_result_reg <= alu_result;
            rsp_err_reg    <= alu_err;
        end
    end

    assign rsp_result = rsp_result_reg;
    assign rsp_err    = rsp_err_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with two requesters.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int N = 2;
    localparam int X = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*4-1:0] req_op;
    logic [N*X-1:0] req_a;
    logic [N*X-1:0] req_b;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic [X-1:0]   rsp_result;
    logic           rsp_err;
    logic           busy;

    int          n_vec = 0;
    int          n_err = 0;
    int          g;
    logic [31:0] er;

    always #5 clk = ~clk;

    alu_share_arbiter #(
        .N_REQ (N),
        .XLEN  (X)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_req(input int idx, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[idx*4 +: 4] = op;
        req_a[idx*X +: X]  = a;
        req_b[idx*X +: X]  = b;
    endtask

    // One complete transaction from a single requester, checked at every stage.
    task automatic do_op(input string tag, input int idx, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_r, input logic exp_e);
        int waited;
        waited = 0;
        set_req(idx, op, a, b);
        req_valid = N'(1 << idx);
        #1;
        while (!req_ready[idx] && waited < 8) begin
            step();
            #1;
            waited++;
        end
        chk($sformatf("%s.ready", tag), 32'(req_ready), 32'(1 << idx));
        step();
        req_valid = '0;
        #1;
        chk($sformatf("%s.exec_busy", tag), 32'(busy), 32'd1);
        chk($sformatf("%s.exec_novalid", tag), 32'(rsp_valid), 32'd0);
        step();
        #1;
        chk($sformatf("%s.rsp_valid", tag), 32'(rsp_valid), 32'(1 << idx));
        chk($sformatf("%s.result", tag), rsp_result, exp_r);
        chk($sformatf("%s.err", tag), 32'(rsp_err), 32'(exp_e));
        rsp_ready = N'(1 << idx);
        step();
        rsp_ready = '0;
        #1;
        chk($sformatf("%s.idle", tag), 32'(busy), 32'd0);
        $display("op %s: req%0d op=%0d a=%h b=%h -> result=%h err=%0b", tag, idx, op, a, b, rsp_result, rsp_err);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = '0;
        step();
        #1;
        chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset.req_ready", 32'(req_ready), 32'd0);
        chk("reset.result", rsp_result, 32'd0);
        chk("reset.err", 32'(rsp_err), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        $display("reset: outputs checked");
        step();
        rst_n     = 1'b1;
        req_valid = '0;
        #1;

        // Round-robin with both requesters continuously valid
        set_req(0, ALU_SUB, 32'd3, 32'd5);
        set_req(1, ALU_SLTU, 32'd3, 32'd5);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            g  = k % 2;
            er = (g == 1) ? 32'd1 : 32'hFFFFFFFE;
            chk("rr.grant", 32'(req_ready), 32'(1 << g));
            step();
            #1;
            chk("rr.exec_ready", 32'(req_ready), 32'd0);
            step();
            #1;
            chk("rr.rsp_valid", 32'(rsp_valid), 32'(1 << g));
            chk("rr.result", rsp_result, er);
            $display("rr: grant %0d result=%h", g, rsp_result);
            step();
            #1;
        end
        req_valid = '0;
        rsp_ready = '0;
        step();
        #1;

        // Single op with response back-pressure
        set_req(0, ALU_ADD, 32'd5, 32'd7);
        req_valid = 2'b01;
        #1;
        chk("add.ready", 32'(req_ready), 32'd1);
        step();
        req_valid = '0;
        #1;
        chk("add.t1_valid", 32'(rsp_valid), 32'd0);
        step();
        #1;
        chk("add.t2_valid", 32'(rsp_valid), 32'd1);
        chk("add.result", rsp_result, 32'd12);
        chk("add.err", 32'(rsp_err), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            #1;
            chk("add.hold_valid", 32'(rsp_valid), 32'd1);
            chk("add.hold_result", rsp_result, 32'd12);
        end
        rsp_ready = 2'b01;
        step();
        rsp_ready = '0;
        #1;
        chk("add.idle", 32'(busy), 32'd0);
        $display("add: 5+7 result=%h", rsp_result);

        do_op("invalid", 1, ALU_INVALID, 32'd0, 32'd0, 32'hDEADBEEF, 1'b1);
        do_op("and", 1, ALU_AND, 32'hF0, 32'h3C, 32'h30, 1'b0);

        // Back-pressure: req 0 stalls its response while req 1 waits
        set_req(0, ALU_ADD, 32'd1, 32'd2);
        set_req(1, ALU_XOR, 32'hFF, 32'h0F);
        req_valid = 2'b11;
        #1;
        chk("bp.grant0", 32'(req_ready), 32'd1);
        step();
        req_valid = 2'b10;
        #1;
        chk("bp.exec_ready", 32'(req_ready), 32'd0);
        step();
        #1;
        chk("bp.rsp0", 32'(rsp_valid), 32'd1);
        chk("bp.result0", rsp_result, 32'd3);
        for (int k = 0; k < 3; k++) begin
            step();
            #1;
            chk("bp.stall_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 2'b10;
        step();
        #1;
        chk("bp.other_ready_ignored", 32'(rsp_valid), 32'd1);
        rsp_ready = 2'b01;
        step();
        rsp_ready = '0;
        #1;
        chk("bp.grant1", 32'(req_ready), 32'd2);
        step();
        req_valid = '0;
        #1;
        chk("bp.exec1", 32'(busy), 32'd1);
        step();
        #1;
        chk("bp.rsp1", 32'(rsp_valid), 32'd2);
        chk("bp.result1", rsp_result, 32'hF0);
        rsp_ready = 2'b10;
        step();
        rsp_ready = '0;
        #1;
        chk("bp.idle", 32'(busy), 32'd0);
        $display("bp: req1 result=%h", rsp_result);

        do_op("sll", 0, ALU_SLL, 32'd1, 32'd31, 32'h80000000, 1'b0);
        do_op("srl", 1, ALU_SRL, 32'h80000000, 32'h3F, 32'd1, 1'b0);
        do_op("slt", 0, ALU_SLT, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0);
        do_op("sra", 1, ALU_SRA, 32'h80000000, 32'd4, 32'hF8000000, 1'b0);
        do_op("nop", 0, ALU_NOP, 32'h123, 32'h456, 32'd0, 1'b0);
        do_op("undef", 1, 4'd12, 32'd1, 32'd1, 32'hDEADBEEF, 1'b1);

        // Asynchronous reset in the middle of RESP
        set_req(0, ALU_ADD, 32'd5, 32'd7);
        req_valid = 2'b01;
        #1;
        step();
        req_valid = '0;
        step();
        #1;
        chk("rstmid.rsp_valid_before", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rstmid.busy", 32'(busy), 32'd0);
        step();
        rst_n     = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("rstmid.first_grant", 32'(req_ready), 32'd1);
        $display("rstmid: first grant after reset=%b", req_ready);
        req_valid = '0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
